// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared font table, segment width and anode one-hot helper for the seven-segment scanner
package sevseg_pkg;

    localparam int SEG_W = 7;

    // Active-high a..g patterns, index = hex nibble (entry 0 is the rightmost in this list)
    localparam logic [15:0][SEG_W-1:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [15:0] onehot_an(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/sevseg_scan_ctrl_if.sv
// sevseg_scan_ctrl_if: valid/ready value-load bus into the seven-segment scanner
interface sevseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] i_value;
    logic                    i_valid;
    logic                    o_ready;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [NUM_DIGITS-1:0]   i_blank;

    modport master (output i_value, i_valid, i_dp, i_blank, input o_ready);
    modport slave  (input i_value, i_valid, i_dp, i_blank, output o_ready);
endinterface

// File: rtl/sevseg_hex_decode.sv
// sevseg_hex_decode: combinational hex nibble to active-high a..g segment pattern
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);
    assign o_seg = FONT[i_nib];
endmodule

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: multiplexed seven-segment scanner with dead time, tear-free frame-boundary
// updates and selectable polarity. Define SEVSEG_LZ_SUPPRESS_EN to blank leading zero digits.
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int PRESCALE       = 1024,
    parameter int DEAD_CYCLES    = 4,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                  clk_core,
    input  logic                  rstn,
    sevseg_scan_ctrl_if.slave     s_bus,
    input  logic                  i_enable,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [SEG_W-1:0]      o_seg,
    output logic                  o_dp,
    output logic                  o_frame
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]         CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]         DEAD    = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;
    localparam logic [SEG_W-1:0]      SEG_OFF = (ACTIVE_LOW_SEG != 0) ? '1 : '0;
    localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);

    logic [CW-1:0]                 r_cnt;
    logic [IW-1:0]                 r_idx;
    logic [NUM_DIGITS-1:0][3:0]    r_disp_val, r_pend_val;
    logic [NUM_DIGITS-1:0]         r_disp_dp, r_pend_dp, r_disp_blank, r_pend_blank;
    logic                          r_pend_vld;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [SEG_W-1:0]              r_seg;
    logic                          r_dp;
    logic                          r_frame;

    logic                          w_tick, w_bound, w_load, w_capture, w_on;
    logic [CW-1:0]                 w_cnt_nx;
    logic [IW-1:0]                 w_idx_nx;
    logic [NUM_DIGITS-1:0][3:0]    w_disp_val_nx;
    logic [NUM_DIGITS-1:0]         w_disp_dp_nx, w_disp_blank_nx, w_lz, w_blank_eff;
    logic [15:0]                   w_oh;
    logic [NUM_DIGITS-1:0]         w_an_hi;
    logic [3:0]                    w_nib;
    logic [SEG_W-1:0]              w_font;

    assign w_tick    = (r_cnt == CNT_MAX);
    assign w_bound   = w_tick && (r_idx == IDX_MAX);
    assign w_load    = w_bound && r_pend_vld;
    assign w_capture = s_bus.i_valid && !r_pend_vld;
    assign w_cnt_nx  = w_tick ? '0 : r_cnt + 1'b1;
    assign w_idx_nx  = !w_tick ? r_idx : (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;

    // Outputs look at the display contents as they will be after this edge, so a new
    // value shows from the first cycle of the new frame.
    assign w_disp_val_nx   = w_load ? r_pend_val   : r_disp_val;
    assign w_disp_dp_nx    = w_load ? r_pend_dp    : r_disp_dp;
    assign w_disp_blank_nx = w_load ? r_pend_blank : r_disp_blank;

`ifdef SEVSEG_LZ_SUPPRESS_EN
    // A digit above the most-significant nonzero nibble is dark; digit 0 always shows
    always_comb begin
        logic v_seen;
        v_seen = 1'b0;
        w_lz   = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            v_seen  = v_seen | (w_disp_val_nx[k] != 4'h0);
            w_lz[k] = !v_seen;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_blank_eff = w_disp_blank_nx | w_lz;
    assign w_on        = (w_cnt_nx >= DEAD) && i_enable && !w_blank_eff[w_idx_nx];
    assign w_oh        = onehot_an(4'(w_idx_nx));
    assign w_an_hi     = w_on ? w_oh[NUM_DIGITS-1:0] : '0;
    assign w_nib       = w_disp_val_nx[w_idx_nx];

    sevseg_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_font)
    );

    // Prescaler and digit index scan continuously, independent of enable and handshake
    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_idx <= w_idx_nx;
        end
    end

    // Pending slot accepts one value; it moves to the display only at a frame boundary
    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_vld   <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
        end else if (w_load) begin
            r_disp_val   <= r_pend_val;
            r_disp_dp    <= r_pend_dp;
            r_disp_blank <= r_pend_blank;
            r_pend_vld   <= 1'b0;
        end else if (w_capture) begin
            r_pend_val   <= s_bus.i_value;
            r_pend_dp    <= s_bus.i_dp;
            r_pend_blank <= s_bus.i_blank;
            r_pend_vld   <= 1'b1;
        end
    end

    // Registered pin drive; XOR with the inactive level applies the polarity
    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_hi ^ AN_OFF;
            r_seg   <= (w_on ? w_font : '0) ^ SEG_OFF;
            r_dp    <= (w_on && w_disp_dp_nx[w_idx_nx]) ^ DP_OFF;
            r_frame <= w_bound;
        end
    end

    assign s_bus.o_ready = !r_pend_vld;
    assign o_an          = r_an;
    assign o_seg         = r_seg;
    assign o_dp          = r_dp;
    assign o_frame       = r_frame;

endmodule
